fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Stage 1 of the 4-stage 8-bit pipeline. Owns the PC, drives instruction-memory address, registers the IF/ID latch.
// - Its output instr[7:6] is the opcode consumed by decode/control (00 addi, 01 sll, 11 jmp, 10 undefined).
// - Handles hazard stalls, jump redirect with flush, and filtering of undefined opcodes.
// PARAMETERS
// - PC_W      8      PC / imem address width; PC wraps mod 2^PC_W
// - INSTR_W   8      instruction width; opcode = instr[INSTR_W-1 -: 2], jmp target = instr[5:0]
// - RESET_PC  0      PC value loaded on reset
// PORTS
// - clk             in   1        single clock, rising edge
// - rst_n           in   1        asynchronous, active-low reset
// - stall           in   1        hazard stall from decode; freeze PC and IF/ID
// - id_jump         in   1        jump resolved in ID (control jump & if_id_valid)
// - id_jump_target  in   PC_W     absolute jump target from ID (zero-extended instr[5:0])
// - imem_addr       out  PC_W     instruction memory address (= pc, combinational)
// - imem_rdata      in   INSTR_W  instruction memory data, combinational read of imem_addr
// - pc              out  PC_W     current fetch PC
// - if_id_instr     out  INSTR_W  IF/ID instruction
// - if_id_pc        out  PC_W     IF/ID PC of that instruction
// - if_id_valid     out  1        IF/ID holds a real instruction (downstream gates RegWrite with it)
// - illegal_op      out  1        1-cycle pulse: opcode 10 fetched and dropped
// BEHAVIOUR
// - Reset (async, rst_n=0): pc=RESET_PC; if_id_instr=0; if_id_pc=0; if_id_valid=0; illegal_op=0. Mid-operation reset discards all in-flight state immediately.
// - imem_addr = pc; fetch latency 1 cycle: instr at pc appears in IF/ID after next rising edge.
// - Per rising edge, priority stall > jump > sequential:
//   - stall=1: pc, if_id_* hold; illegal_op=0; id_jump ignored (ID instr re-presented later).
//   - id_jump=1 (no stall): pc<=id_jump_target; if_id_valid<=0, if_id_instr<=0 (flush wrong-path fetch). One-bubble penalty.
//   - else: if_id_instr<=imem_rdata; if_id_pc<=pc; if_id_valid<=1; pc<=pc+1 (PC_W bits, 2^PC_W-1 wraps to 0).
// - Undefined opcode 10 on a sequential capture: if_id_instr<=0, if_id_valid<=0, illegal_op<=1 for that cycle; pc still advances.
// - illegal_op is 0 in every other cycle; it is never asserted on a flushed or stalled cycle.
// - if_id_valid=0 cycles (reset exit, flush, illegal) are bubbles; if_id_pc is don't-care but stays registered.
// - First edge after reset release captures instr at RESET_PC with valid=1.
// CONFIGURATION
// - Macro JUMP_EARLY_EN:
//   - Defined: IF pre-decodes imem_rdata opcode; when opcode 11 is captured (no stall), pc<={0,imem_rdata[5:0]} instead of pc+1.
//     The jmp itself enters IF/ID valid=1. id_jump/id_jump_target are ignored. Zero-bubble jumps.
//   - Undefined: jumps resolved only via id_jump, with the one-bubble flush above. The pre-decode logic is absent.
// TESTING
// - Reset release, imem[0..2]=05,46,07 -> pc 0,1,2,3; IF/ID shows (05,pc0,v1),(46,pc1,v1),(07,pc2,v1).
// - stall=1 for 2 cycles with pc=3 -> pc stays 3, IF/ID unchanged. Release -> imem[3] captured next edge.
// - Macro off: imem[2]=CA; id_jump=1, target=0A while CA in ID -> pc=0A next edge, imem[3] flushed (valid=0 one cycle), then imem[0A] valid.
// - Macro on: same program -> pc goes 2->0A directly, no bubble, imem[3] never valid in IF/ID.
// - pc=FF, sequential -> pc=00 next edge; imem[FF] captured with if_id_pc=FF.
// - imem[1]=80 -> illegal_op=1 one cycle, if_id_valid=0, pc 1->2. Assert rst_n=0 mid-stream -> all outputs cleared same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// Module: fetch_stage
// Purpose:
//   Stage 1 of the 4-stage 8-bit pipeline. Owns the program counter, drives
//   the instruction-memory address and registers the IF/ID latch. Handles
//   hazard stalls, jump redirect with a wrong-path flush, and dropping of the
//   undefined opcode 10 (reported with a one-cycle illegal_op pulse).
//
// Configuration:
//   JUMP_EARLY_EN  When defined, IF pre-decodes the fetched opcode and takes
//                  jmp (opcode 11) immediately, so jumps cost no bubble and
//                  id_jump/id_jump_target are ignored. When undefined, jumps
//                  are resolved in ID through id_jump and cost one bubble.
//
// Ports:
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous active-low reset
//   stall           in   1        hazard stall from decode; freezes PC and IF/ID
//   id_jump         in   1        jump resolved in ID
//   id_jump_target  in   PC_W     absolute jump target from ID
//   imem_addr       out  PC_W     instruction memory address (= pc)
//   imem_rdata      in   INSTR_W  combinational instruction memory data
//   pc              out  PC_W     current fetch PC
//   if_id_instr     out  INSTR_W  IF/ID instruction
//   if_id_pc        out  PC_W     PC of the IF/ID instruction
//   if_id_valid     out  1        IF/ID holds a real instruction
//   illegal_op      out  1        one-cycle pulse: opcode 10 fetched and dropped
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               id_jump,
    input  logic [PC_W-1:0]    id_jump_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               illegal_op
);

    localparam logic [1:0] OP_UNDEF = 2'b10;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ifPc_q, ifPc_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;

    logic [1:0]         opcode;
    logic               redirectId;
    logic               earlyJump;
    logic [PC_W-1:0]    earlyTarget;
    logic [PC_W-1:0]    pcPlusOne;

    assign opcode    = imem_rdata[INSTR_W-1 -: 2];
    assign pcPlusOne = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef JUMP_EARLY_EN
    localparam logic [1:0] OP_JMP = 2'b11;

    // The ID-stage redirect is not needed when jumps are taken in IF; the
    // inputs stay on the port list so both builds share one interface.
    logic unusedIdJump;
    assign unusedIdJump = ^{id_jump, id_jump_target};

    assign redirectId  = 1'b0;
    assign earlyJump   = (opcode == OP_JMP);
    assign earlyTarget = {{(PC_W-6){1'b0}}, imem_rdata[5:0]};
`else
    assign redirectId  = id_jump;
    assign earlyJump   = 1'b0;
    assign earlyTarget = '0;
`endif

    // Next-state selection with priority stall > ID redirect > sequential.
    // A stall holds everything, including any pending ID jump, because the
    // jump instruction is re-presented to ID once the stall clears.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifPc_d    = ifPc_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;

        if (!stall) begin
            if (redirectId) begin
                // The word fetched this cycle is on the wrong path: flush it.
                pc_d    = id_jump_target;
                instr_d = '0;
                valid_d = 1'b0;
            end else begin
                ifPc_d = pc_q;
                pc_d   = earlyJump ? earlyTarget : pcPlusOne;
                if (opcode == OP_UNDEF) begin
                    // Undefined opcode becomes a bubble; fetch keeps going.
                    instr_d   = '0;
                    valid_d   = 1'b0;
                    illegal_d = 1'b1;
                end else begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                end
            end
        end
    end

    // PC and IF/ID latch; reset discards all in-flight state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ifPc_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifPc_q    <= ifPc_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifPc_q;
    assign if_id_valid = valid_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// Testbench: tb_fetch_stage
// Purpose:
//   Directed bench for fetch_stage with an instruction memory model. Each
//   stimulus step pushes the expected post-edge state onto a scoreboard queue,
//   which is popped and compared one cycle later. A few fixed constants from
//   the program layout are also compared directly. Works with and without
//   JUMP_EARLY_EN.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef JUMP_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       id_jump;
    logic [7:0] id_jump_target;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] pc;
    logic [7:0] if_id_instr;
    logic [7:0] if_id_pc;
    logic       if_id_valid;
    logic       illegal_op;

    logic [7:0] imem [256];

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
        logic [7:0] ifPc;
        logic       valid;
        logic       illegal;
    } expT;

    expT expQ[$];
    expT model;
    int  errors = 0;
    int  checks = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .illegal_op     (illegal_op)
    );

    assign imem_rdata = imem[imem_addr];

    always #5 clk = ~clk;

    // Hard stop if the sequence ever fails to progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare the DUT against the oldest scoreboard entry. if_id_pc is only
    // meaningful while the latch holds a valid instruction.
    task automatic checkOutput(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            checkVal({tag, ".pc"}, pc, e.pc);
            checkVal({tag, ".valid"}, {7'b0, if_id_valid}, {7'b0, e.valid});
            checkVal({tag, ".illegal"}, {7'b0, illegal_op}, {7'b0, e.illegal});
            checkVal({tag, ".instr"}, if_id_instr, e.instr);
            if (e.valid) checkVal({tag, ".ifpc"}, if_id_pc, e.ifPc);
        end
    endtask

    // One clock of stimulus. id_jump mirrors what decode would raise: a valid
    // jmp sitting in IF/ID. The expected next state goes on the scoreboard.
    task automatic applyStimulus(input string tag, input logic stallV);
        logic       jumpV;
        logic [7:0] tgt;
        logic [7:0] rd;
        expT        e;
        jumpV = model.valid && (model.instr[7:6] == 2'b11);
        tgt   = {2'b00, model.instr[5:0]};
        stall          = stallV;
        id_jump        = jumpV;
        id_jump_target = tgt;
        e         = model;
        e.illegal = 1'b0;
        if (!stallV) begin
            if (jumpV && !EARLY) begin
                e.pc    = tgt;
                e.instr = 8'h00;
                e.valid = 1'b0;
            end else begin
                rd     = imem[model.pc];
                e.ifPc = model.pc;
                e.pc   = model.pc + 8'd1;
                if (rd[7:6] == 2'b10) begin
                    e.instr   = 8'h00;
                    e.valid   = 1'b0;
                    e.illegal = 1'b1;
                end else begin
                    e.instr = rd;
                    e.valid = 1'b1;
                end
                if (EARLY && rd[7:6] == 2'b11) e.pc = {2'b00, rd[5:0]};
            end
        end
        expQ.push_back(e);
        model = e;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Assert reset between edges and confirm it takes effect without a clock.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #2;
        checkVal({tag, ".pc"}, pc, 8'h00);
        checkVal({tag, ".instr"}, if_id_instr, 8'h00);
        checkVal({tag, ".ifpc"}, if_id_pc, 8'h00);
        checkVal({tag, ".valid"}, {7'b0, if_id_valid}, 8'h00);
        checkVal({tag, ".illegal"}, {7'b0, illegal_op}, 8'h00);
        model = '0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fillImem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h05;
    endtask

    initial begin
        stall          = 1'b0;
        id_jump        = 1'b0;
        id_jump_target = 8'h00;
        rst_n          = 1'b0;
        fillImem();
        imem[0] = 8'h05;
        imem[1] = 8'h46;
        imem[2] = 8'h07;
        imem[3] = 8'h13;

        // Phase 1: sequential fetch after reset, then a two-cycle stall.
        #3;
        doReset("reset0");
        applyStimulus("seq0", 1'b0);
        checkVal("seq0.direct", if_id_instr, 8'h05);
        applyStimulus("seq1", 1'b0);
        applyStimulus("seq2", 1'b0);
        checkVal("seq2.directPc", pc, 8'h03);
        checkVal("seq2.directInstr", if_id_instr, 8'h07);
        applyStimulus("stall0", 1'b1);
        applyStimulus("stall1", 1'b1);
        checkVal("stall.directPc", pc, 8'h03);
        applyStimulus("unstall", 1'b0);
        checkVal("unstall.direct", if_id_instr, 8'h13);

        // Phase 2: mid-stream reset, then a jmp CA at address 2 to 0A.
        // A stall while the jmp sits in ID must hold the redirect back.
        #1;
        imem[2]    = 8'hCA;
        imem[3]    = 8'h33;
        imem[8'h0A] = 8'h21;
        imem[8'h0B] = 8'h04;
        doReset("reset1");
        applyStimulus("jseq0", 1'b0);
        applyStimulus("jseq1", 1'b0);
        applyStimulus("jcap", 1'b0);
        checkVal("jcap.directPc", pc, EARLY ? 8'h0A : 8'h03);
        applyStimulus("jstall", 1'b1);
        applyStimulus("jredir", 1'b0);
        checkVal("jredir.directPc", pc, EARLY ? 8'h0B : 8'h0A);
        applyStimulus("jland", 1'b0);
        checkVal("jland.directInstr", if_id_instr, EARLY ? 8'h04 : 8'h21);

        // Phase 3: undefined opcode at address 1, then run up to the wrap.
        #1;
        fillImem();
        imem[1]    = 8'h80;
        imem[8'hFF] = 8'h3C;
        doReset("reset2");
        applyStimulus("ill0", 1'b0);
        applyStimulus("ill1", 1'b0);
        checkVal("ill1.directPulse", {7'b0, illegal_op}, 8'h01);
        checkVal("ill1.directPc", pc, 8'h02);
        applyStimulus("ill2", 1'b0);
        for (int n = 0; n < 300 && model.pc != 8'hFF; n++) applyStimulus("run", 1'b0);
        checkVal("reachFF", pc, 8'hFF);
        applyStimulus("wrap", 1'b0);
        checkVal("wrap.directPc", pc, 8'h00);
        checkVal("wrap.directIfPc", if_id_pc, 8'hFF);
        checkVal("wrap.directInstr", if_id_instr, 8'h3C);
        applyStimulus("wrap1", 1'b0);

        // Final asynchronous reset in the middle of activity.
        #1;
        doReset("reset3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
